// File: rtl/if_id_hazard_control.sv
// IF/ID hazard control: load-use stall, taken-branch flush with one shadow cycle, memory freeze.
// Control outputs are combinational from state and inputs; state and saturating counters are registered.
module if_id_hazard_control #(
   parameter int CNT_WIDTH = 32,
   parameter int ZERO_REG  = 31
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [4:0]           rn_ID,
   input  logic [4:0]           rm_ID,
   input  logic                 uses_rn_ID,
   input  logic                 uses_rm_ID,
   input  logic                 memRead_EX,
   input  logic [4:0]           rd_EX,
   input  logic                 branch_taken_MEM,
   input  logic                 mem_busy,
   output logic                 pc_write,
   output logic                 if_id_write,
   output logic                 flush_IF_ID,
   output logic                 flush_ID_EX,
   output logic                 flush_EX_MEM,
   output logic                 id_ex_bubble,
   output logic [CNT_WIDTH-1:0] stall_count,
   output logic [CNT_WIDTH-1:0] flush_count,
   output logic [CNT_WIDTH-1:0] freeze_count
);

   typedef enum logic [1:0] {
      RUN          = 2'd0,
      FLUSH_SHADOW = 2'd1,
      FREEZE       = 2'd2
   } state_t;

   localparam logic [4:0]           ZERO_IDX = 5'(ZERO_REG);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};
   localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

   state_t               state_q, state_d;
   logic [CNT_WIDTH-1:0] stall_count_q, stall_count_d;
   logic [CNT_WIDTH-1:0] flush_count_q, flush_count_d;
   logic [CNT_WIDTH-1:0] freeze_count_q, freeze_count_d;

   logic load_use;
   logic stall_inc, flush_inc, freeze_inc;

   assign load_use = memRead_EX && (rd_EX != ZERO_IDX) &&
                     ((uses_rn_ID && (rn_ID == rd_EX)) ||
                      (uses_rm_ID && (rm_ID == rd_EX)));

   always_comb begin
      pc_write     = 1'b1;
      if_id_write  = 1'b1;
      flush_IF_ID  = 1'b0;
      flush_ID_EX  = 1'b0;
      flush_EX_MEM = 1'b0;
      id_ex_bubble = 1'b0;
      state_d      = RUN;
      stall_inc    = 1'b0;
      flush_inc    = 1'b0;
      freeze_inc   = 1'b0;

      if (mem_busy) begin
         pc_write    = 1'b0;
         if_id_write = 1'b0;
         state_d     = FREEZE;
         freeze_inc  = 1'b1;
      end else if (branch_taken_MEM) begin
         flush_IF_ID  = 1'b1;
         flush_ID_EX  = 1'b1;
         flush_EX_MEM = 1'b1;
         state_d      = FLUSH_SHADOW;
         flush_inc    = 1'b1;
      end else if (load_use && (state_q != FLUSH_SHADOW)) begin
         // ID holds a flushed bubble during the shadow cycle, so no stall there
         pc_write     = 1'b0;
         if_id_write  = 1'b0;
         id_ex_bubble = 1'b1;
         stall_inc    = 1'b1;
      end

      if (reset) begin
         pc_write     = 1'b0;
         if_id_write  = 1'b0;
         flush_IF_ID  = 1'b1;
         flush_ID_EX  = 1'b1;
         flush_EX_MEM = 1'b1;
         id_ex_bubble = 1'b1;
         state_d      = RUN;
         stall_inc    = 1'b0;
         flush_inc    = 1'b0;
         freeze_inc   = 1'b0;
      end
   end

   always_comb begin
      stall_count_d  = stall_count_q;
      flush_count_d  = flush_count_q;
      freeze_count_d = freeze_count_q;
      if (stall_inc && (stall_count_q != CNT_MAX))
         stall_count_d = stall_count_q + CNT_ONE;
      if (flush_inc && (flush_count_q != CNT_MAX))
         flush_count_d = flush_count_q + CNT_ONE;
      if (freeze_inc && (freeze_count_q != CNT_MAX))
         freeze_count_d = freeze_count_q + CNT_ONE;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q        <= RUN;
         stall_count_q  <= '0;
         flush_count_q  <= '0;
         freeze_count_q <= '0;
      end else begin
         state_q        <= state_d;
         stall_count_q  <= stall_count_d;
         flush_count_q  <= flush_count_d;
         freeze_count_q <= freeze_count_d;
      end
   end

   assign stall_count  = stall_count_q;
   assign flush_count  = flush_count_q;
   assign freeze_count = freeze_count_q;

endmodule
